// File: rtl/parking_occupancy_display_if.sv
// Sensor, control and display signals for parking_occupancy_display.
// slave is the occupancy block's view; master is the driving/observing side.
interface parking_occupancy_display_if #(
    parameter int unsigned NUM_SLOTS  = 15,
    parameter int unsigned NUM_DIGITS = 4
);
    localparam int unsigned CNT_W = $clog2(NUM_SLOTS + 1);

    logic [NUM_SLOTS-1:0]  cars;
    logic                  show_free;
    logic [CNT_W-1:0]      count;
    logic                  full;
    logic                  empty;
    logic                  occ_inc;
    logic                  occ_dec;
    logic [6:0]            seg;
    logic [NUM_DIGITS-1:0] an;

    modport slave (
        input  cars, show_free,
        output count, full, empty, occ_inc, occ_dec, seg, an
    );

    modport master (
        output cars, show_free,
        input  count, full, empty, occ_inc, occ_dec, seg, an
    );
endinterface

// File: rtl/parking_occupancy_display.sv
// Debounced slot occupancy counter with flags, change pulses and a scanned
// multi-digit seven-segment readout of occupied or free slots.
module parking_occupancy_display #(
    parameter int unsigned NUM_SLOTS       = 15,
    parameter int unsigned NUM_DIGITS      = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REFRESH_DIV     = 100000
) (
    input  logic clk,
    input  logic rst,
    parking_occupancy_display_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(NUM_SLOTS + 1);
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned PR_W  = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned BCD_W = 4 * NUM_DIGITS;

    logic [NUM_SLOTS-1:0]           sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NUM_SLOTS-1:0]           deb_q, deb_d;
    logic [NUM_SLOTS-1:0][DB_W-1:0] dbc_q, dbc_d;
    logic [CNT_W-1:0]               count_q, count_d, pop;
    logic                           full_q, full_d, empty_q, empty_d;
    logic                           inc_q, inc_d, dec_q, dec_d;
    logic [PR_W-1:0]                presc_q, presc_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [NUM_DIGITS-1:0]          an_q, an_d;
    logic [6:0]                     seg_q, seg_d;

    logic [CNT_W-1:0]      disp_val;
    logic [BCD_W-1:0]      bcd;
    logic [NUM_DIGITS-1:0] blank;
    logic [3:0]            sel_digit;
    logic                  sel_blank;
    logic                  seen;
    logic                  tick;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        sync1_d = bus.cars;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        dbc_d   = dbc_q;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                dbc_d[i] = '0;
            end else if (dbc_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_d[i] = sync2_q[i];
                dbc_d[i] = '0;
            end else begin
                dbc_d[i] = dbc_q[i] + DB_W'(1);
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            pop = pop + CNT_W'(deb_q[i]);
        end
        count_d = pop;
        full_d  = (pop == CNT_W'(NUM_SLOTS));
        empty_d = (pop == '0);
        inc_d   = (pop > count_q);
        dec_d   = (pop < count_q);
    end

    always_comb begin
        disp_val = bus.show_free ? (CNT_W'(NUM_SLOTS) - count_q) : count_q;
        bcd = '0;
        for (int unsigned b = CNT_W; b > 0; b--) begin
            for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
                if (bcd[d*4 +: 4] >= 4'd5) bcd[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
            end
            bcd = {bcd[BCD_W-2:0], disp_val[b-1]};
        end
        // Blank every digit with no non-zero digit at or above it, except digit 0.
        seen = 1'b0;
        for (int unsigned k = NUM_DIGITS; k > 0; k--) begin
            seen       = seen | (bcd[(k-1)*4 +: 4] != 4'd0);
            blank[k-1] = ~seen && (k != 1);
        end
        sel_digit = '0;
        sel_blank = 1'b1;
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            if (idx_q == IDX_W'(d)) begin
                sel_digit = bcd[d*4 +: 4];
                sel_blank = blank[d];
            end
        end
    end

    // idx_q names the digit to drive on the coming tick, so the first tick
    // after reset lights digit 0 and the index then moves on.
    always_comb begin
        tick    = (presc_q == PR_W'(REFRESH_DIV - 1));
        presc_d = tick ? '0 : presc_q + PR_W'(1);
        idx_d   = idx_q;
        an_d    = an_q;
        seg_d   = seg_q;
        if (tick) begin
            an_d  = ~(NUM_DIGITS'(1) << idx_q);
            seg_d = sel_blank ? '1 : seg7(sel_digit);
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            dbc_q   <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            presc_q <= '0;
            idx_q   <= '0;
            an_q    <= '1;
            seg_q   <= '1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            dbc_q   <= dbc_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            inc_q   <= inc_d;
            dec_q   <= dec_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign bus.count   = count_q;
    assign bus.full    = full_q;
    assign bus.empty   = empty_q;
    assign bus.occ_inc = inc_q;
    assign bus.occ_dec = dec_q;
    assign bus.seg     = seg_q;
    assign bus.an      = an_q;
endmodule

// File: tb/tb_parking_occupancy_display.sv
// Directed bench for parking_occupancy_display with small debounce and refresh
// settings; expected values are worked out by hand from the block's timing.
module tb_parking_occupancy_display;
    localparam int unsigned NS = 15;
    localparam int unsigned ND = 4;
    localparam int unsigned DC = 4;
    localparam int unsigned RD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    parking_occupancy_display_if #(.NUM_SLOTS(NS), .NUM_DIGITS(ND)) bus ();

    parking_occupancy_display #(
        .NUM_SLOTS(NS),
        .NUM_DIGITS(ND),
        .DEBOUNCE_CYCLES(DC),
        .REFRESH_DIV(RD)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [6:0] cap [ND];
    logic [3:0] prev_an;
    int n_inc;
    int ticks;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic capture();
        for (int d = 0; d < ND; d++) cap[d] = 7'h55;
        repeat (16) begin
            step(1);
            for (int d = 0; d < ND; d++) begin
                if (bus.an == ~(4'b0001 << d)) cap[d] = bus.seg;
            end
        end
    endtask

    initial begin
        bus.cars      = '0;
        bus.show_free = 1'b0;

        // power-on reset
        #12;
        check("rst_count", int'(bus.count), 0);
        check("rst_empty", int'(bus.empty), 1);
        check("rst_full", int'(bus.full), 0);
        check("rst_inc", int'(bus.occ_inc), 0);
        check("rst_dec", int'(bus.occ_dec), 0);
        check("rst_an", int'(bus.an), 'hF);
        check("rst_seg", int'(bus.seg), 'h7F);
        @(posedge clk);
        #3 rst = 1'b0;
        step(3);
        check("first_tick_an_pre", int'(bus.an), 'hF);
        step(1);
        check("first_tick_an", int'(bus.an), 'hE);
        check("first_tick_seg", int'(bus.seg), 'h40);

        // short glitch is rejected
        bus.cars[3] = 1'b1;
        step(3);
        bus.cars[3] = 1'b0;
        for (int e = 0; e < 10; e++) begin
            step(1);
            check("glitch_count", int'(bus.count), 0);
            check("glitch_inc", int'(bus.occ_inc), 0);
        end

        // stable change lands DC+3 edges later
        bus.cars[3] = 1'b1;
        step(6);
        check("lat_count_early", int'(bus.count), 0);
        step(1);
        check("lat_count", int'(bus.count), 1);
        check("lat_inc", int'(bus.occ_inc), 1);
        check("lat_empty", int'(bus.empty), 0);
        step(1);
        check("lat_inc_pulse", int'(bus.occ_inc), 0);

        // asynchronous mid-cycle reset, sensor must be re-debounced
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("mrst_count", int'(bus.count), 0);
        check("mrst_empty", int'(bus.empty), 1);
        check("mrst_an", int'(bus.an), 'hF);
        check("mrst_seg", int'(bus.seg), 'h7F);
        #2 rst = 1'b0;
        step(3);
        check("mrst_an_pre", int'(bus.an), 'hF);
        step(1);
        check("mrst_an_tick", int'(bus.an), 'hE);
        check("mrst_seg_tick", int'(bus.seg), 'h40);
        step(2);
        check("mrst_count_early", int'(bus.count), 0);
        step(1);
        check("mrst_count_back", int'(bus.count), 1);

        // clear everything: decrement pulse
        bus.cars = '0;
        step(6);
        check("clr_count_early", int'(bus.count), 1);
        step(1);
        check("clr_count", int'(bus.count), 0);
        check("clr_dec", int'(bus.occ_dec), 1);
        check("clr_inc", int'(bus.occ_inc), 0);
        check("clr_empty", int'(bus.empty), 1);

        // all slots at once: single step to full
        bus.cars = '1;
        n_inc = 0;
        for (int e = 1; e <= 12; e++) begin
            step(1);
            n_inc += int'(bus.occ_inc);
            if (e == 7) begin
                check("full_count", int'(bus.count), 15);
                check("full_flag", int'(bus.full), 1);
                check("full_empty", int'(bus.empty), 0);
                check("full_inc", int'(bus.occ_inc), 1);
            end
        end
        check("full_inc_pulses", n_inc, 1);
        step(16);
        capture();
        check("disp15_d0", int'(cap[0]), 'h12);
        check("disp15_d1", int'(cap[1]), 'h79);
        check("disp15_d2", int'(cap[2]), 'h7F);
        check("disp15_d3", int'(cap[3]), 'h7F);

        // simultaneous in/out at count 5
        bus.cars = 15'h001F;
        step(10);
        check("five_count", int'(bus.count), 5);
        bus.cars = 15'h021E;
        for (int e = 0; e < 12; e++) begin
            step(1);
            check("swap_count", int'(bus.count), 5);
            check("swap_inc", int'(bus.occ_inc), 0);
            check("swap_dec", int'(bus.occ_dec), 0);
        end

        // occupied vs free display at count 12
        bus.cars = 15'h0FFF;
        step(10);
        check("twelve_count", int'(bus.count), 12);
        check("twelve_full", int'(bus.full), 0);
        step(16);
        capture();
        check("disp12_d0", int'(cap[0]), 'h24);
        check("disp12_d1", int'(cap[1]), 'h79);
        check("disp12_d2", int'(cap[2]), 'h7F);
        check("disp12_d3", int'(cap[3]), 'h7F);
        bus.show_free = 1'b1;
        step(16);
        capture();
        check("free3_d0", int'(cap[0]), 'h30);
        check("free3_d1", int'(cap[1]), 'h7F);
        check("free3_d2", int'(cap[2]), 'h7F);
        check("free3_d3", int'(cap[3]), 'h7F);

        // scan rotation over 16 ticks
        prev_an = bus.an;
        ticks = 0;
        repeat (64) begin
            step(1);
            check("scan_onehot", $countones(~bus.an), 1);
            if (bus.an != prev_an) begin
                ticks++;
                check("scan_seq", int'(bus.an), int'({prev_an[2:0], prev_an[3]}));
                prev_an = bus.an;
            end
        end
        check("scan_ticks", ticks, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/parking_occupancy_display.md
# parking_occupancy_display

Parametrised, clocked occupancy front-end for the car parking slot system. Debounces a vector of per-slot presence sensors and keeps a registered occupied-slot count with full/empty flags and change pulses. Drives a time-multiplexed, multi-digit seven-segment display showing either occupied or free slots in decimal. Replaces the combinational count-and-single-digit path at the top of the parking design.

## Interface

Parameters:
- NUM_SLOTS, 15, number of slot sensors; legal range 1..9999
- NUM_DIGITS, 4, number of seven-segment digits driven; must be wide enough for NUM_SLOTS in decimal
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a sensor change; minimum 1
- REFRESH_DIV, 100000, clock cycles per digit-scan step; minimum 2
- CNT_W (derived, not overridable), $clog2(NUM_SLOTS+1)

Ports:
- clk  input  1  system clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- cars  input  NUM_SLOTS  raw slot sensors, 1 = car present; asynchronous to clk
- show_free  input  1  0 = display occupied count, 1 = display NUM_SLOTS - count; sampled each cycle
- count  output  CNT_W  registered occupied-slot count
- full  output  1  registered, 1 when count == NUM_SLOTS
- empty  output  1  registered, 1 when count == 0
- occ_inc  output  1  one-cycle pulse, count increased on this edge
- occ_dec  output  1  one-cycle pulse, count decreased on this edge
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- an  output  NUM_DIGITS  digit enables, active-low, bit 0 = rightmost digit

## Operation

- Sync: each cars bit passes through a 2-flop synchroniser; reset value 0.
- Debounce, per bit: stable register deb (reset 0) and counter. Sync output == deb -> counter cleared. Otherwise counter increments. On the cycle the counter would reach DEBOUNCE_CYCLES, deb takes the sync value and the counter clears. Any return to equality before that point clears the counter: glitches shorter than DEBOUNCE_CYCLES are discarded.
- Count: popcount of the deb vector, registered into count each cycle. Multiple slots changing on the same edge produce one net step. Equal in/out changes on the same edge give no pulse.
- Flags: full, empty, occ_inc and occ_dec are registered from the same next-count value, aligned with count. occ_inc and occ_dec are never both 1.
- Display value: show_free ? NUM_SLOTS - count : count. Never negative, because count <= NUM_SLOTS by construction. Converted to NUM_DIGITS BCD digits combinationally (double-dabble).
- Scan: a prescaler counts 0..REFRESH_DIV-1 and wraps; a wrap is a tick. Each tick advances digit index 0 -> 1 -> ... -> NUM_DIGITS-1 -> 0. On each tick, an and seg are registered for the new digit index.
- Leading-zero blanking: a digit above the most significant non-zero digit shows seg = 7'b1111111 while its an stays enabled. Digit 0 always shows a numeral, so value 0 displays "0".
- Decoding: 0..9 map to the standard active-low patterns; for example 0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000.

## Timing

- Reset values: count 0, empty 1, full 0 (or 1 if NUM_SLOTS would be 0, which is illegal), occ_inc 0, occ_dec 0, an all ones, seg 7'b1111111. Digit index, prescaler, all deb registers and debounce counters reset to 0.
- Sensor-to-count latency: a raw change held stable appears on count exactly DEBOUNCE_CYCLES+3 rising edges later. That is 2 synchroniser edges, DEBOUNCE_CYCLES debounce edges and 1 count edge.
- Display: the first digit is driven (an = ~1) at prescaler wrap after reset, edge REFRESH_DIV. A count or show_free change appears on a given digit at that digit's next scan slot, at most NUM_DIGITS*REFRESH_DIV cycles later.
- Exactly one an bit is low at any time after the first tick.
- Reset asserted mid-operation clears everything immediately. After release, sensors already high must be re-debounced, so count climbs from 0 after DEBOUNCE_CYCLES+3 edges.

## Test plan

Bench parameters for all scenarios: NUM_SLOTS=15, NUM_DIGITS=4, DEBOUNCE_CYCLES=4, REFRESH_DIV=4.

- Reset: assert rst asynchronously mid-cycle -> outputs take their reset values immediately: count=0, empty=1, an=4'b1111, seg=7'b1111111. After release, an=4'b1110 with seg=7'b1000000 on the 4th edge.
- Debounce: pulse cars[3] high for 3 cycles -> count stays 0 and no occ_inc. Hold cars[3] high -> count=1 and occ_inc=1 for one cycle, exactly 7 edges after the change.
- Multi-change and full: raise all 15 bits together -> count 0 -> 15 in one step, one occ_inc, full=1, empty=0. Display scan shows digits "1","5" on an bits 1,0; digits 2 and 3 blank.
- Simultaneous in/out: with count=5, drop cars[0] and raise cars[9] on the same edge -> count stays 5, no occ_inc, no occ_dec.
- show_free: count=12, show_free=1 -> displayed value 3. Digit 0 seg=7'b0110000; digits 1-3 blank.
- Scan wrap: observe 16 ticks -> an sequence 1110, 1101, 1011, 0111, repeating with exactly one low bit.
